spi_txn_sequencer: RTL and testbench
====================================

// Module: spi_txn_sequencer
// PURPOSE
//  Transaction front-end for the val/rdy SPI master. Takes one request
//  {data, size, cs, freq}, programs the master's size/cs/freq config
//  registers in a dedicated cycle, then issues the data word. It collects
//  the master's received word, masks it to the packet size and returns it
//  upstream. Sits between the host/config bus and the SPI master.
// PARAMETERS
//  NBITS    34                   max packet width; matches the master's nbits
//  NCS      1                    number of chip selects
//  LOG_BITS $clog2(NBITS)+1      width of the size field
//  LOG_CS   NCS>1?$clog2(NCS):1  width of the cs field
// PORTS
//  clk         in   1         clock
//  reset       in   1         synchronous, active-high
//  req_val     in   1         request valid
//  req_rdy     out  1         request ready
//  req_data    in   NBITS     word to shift out, right-aligned
//  req_size    in   LOG_BITS  bits to transfer, 1..NBITS
//  req_cs      in   LOG_CS    chip-select index
//  req_freq    in   3         SCLK divider code (hold = 2^freq-1 cycles)
//  resp_val    out  1         response valid
//  resp_rdy    in   1         response ready
//  resp_data   out  NBITS     received word, bits >= size forced to 0
//  resp_err    out  1         request rejected; no SPI transfer done
//  busy        out  1         state != IDLE
//  m_recv_val  out  1         data to master, valid
//  m_recv_rdy  in   1         master ready; also gates all config interfaces
//  m_recv_msg  out  NBITS     data to master
//  m_send_val  in   1         master result valid
//  m_send_rdy  out  1         master result ready
//  m_send_msg  in   NBITS     master result
//  m_size_val/m_size_msg  out  1/LOG_BITS  packet-size config
//  m_cs_val/m_cs_msg      out  1/LOG_CS    cs-address config
//  m_freq_val/m_freq_msg  out  1/3         frequency config
// BEHAVIOUR
//  - Reset: state IDLE; all *_val, m_send_rdy, resp_err and busy = 0;
//    resp_data and the latched request = 0; config cache invalid. Reset is
//    shared with the master, so reset mid-transfer aborts both with no
//    response.
//  - FSM states: IDLE, CFG, SEND, WAIT, RESP. req_rdy = (state==IDLE).
//  - IDLE: on req_val, latch all fields. If size==0 or size>NBITS, go to
//    RESP with err=1 and data=0. Otherwise go to CFG.
//  - CFG: m_size_val = m_cs_val = m_freq_val = 1, carrying the latched
//    values. Go to SEND when m_recv_rdy=1. Config must precede data by at
//    least 1 cycle because the master uses its registered size when it
//    loads data.
//  - SEND: m_recv_val=1, m_recv_msg=data. Go to WAIT when m_recv_rdy=1.
//  - WAIT: m_send_rdy=1. When m_send_val=1, capture
//    m_send_msg & ((1<<size)-1) (all ones when size==NBITS), set err=0 and
//    go to RESP. The master then returns to INIT.
//  - RESP: resp_val=1; data and err are stable until accepted. Go to IDLE
//    when resp_rdy=1.
//  - m_recv_val is never asserted while the master holds send_val; this
//    prevents a back-to-back restart before the result is captured.
//  - Latency, req accept -> resp_val: 2 + master transfer time + 1 cycles.
//    Error path: 1 cycle.
//  - Response outputs change only on state entry. No outputs are
//    combinationally dependent on req_val or resp_rdy.
// CONFIGURATION
//  SPI_SEQ_CFG_CACHE_EN defined:
//    - Keep the last programmed {size,cs,freq} plus a valid bit.
//    - On IDLE accept, a valid request whose fields equal the cache skips
//      CFG and goes directly to SEND. This saves 1 cycle.
//    - The cache is loaded on CFG exit; it is invalidated by reset and by
//      error requests.
//  Not defined: every valid request passes through CFG.
// TESTING
//  1. size=8, data=0xA5, cs=0, freq=0, MISO looped to MOSI -> one
//     cfg-val pulse, then one m_recv_val pulse; resp_data=0xA5, err=0.
//  2. size=0 or size=NBITS+1 -> resp_err=1 and resp_data=0 one cycle after
//     accept; m_*_val never asserted.
//  3. size=NBITS, data=all ones, MISO=1 -> resp_data all ones; size=4,
//     MISO=1 -> resp_data=0xF.
//  4. resp_rdy held low 20 cycles after completion -> resp_val and data
//     stable; req_rdy=0; m_send_rdy=0.
//  5. Two identical requests -> with SPI_SEQ_CFG_CACHE_EN, the 2nd has no
//     cfg-val pulse and finishes 1 cycle sooner; without it, both have one
//     pulse.
//  6. reset asserted during WAIT -> next cycle IDLE, busy=0, all vals=0;
//     a new request then completes normally.

Source files
------------

// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : spi_txn_sequencer
// Brief   : Request front-end for the val/rdy SPI master: programs size/cs/freq,
//           issues the data word, returns the size-masked result.
//           Optional config cache: define SPI_SEQ_CFG_CACHE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
  parameter int NBITS    = 34,
  parameter int NCS      = 1,
  parameter int LOG_BITS = $clog2(NBITS) + 1,
  parameter int LOG_CS   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic [NBITS-1:0]    req_data,
  input  logic [LOG_BITS-1:0] req_size,
  input  logic [LOG_CS-1:0]   req_cs,
  input  logic [2:0]          req_freq,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic [NBITS-1:0]    resp_data,
  output logic                resp_err,
  output logic                busy,
  output logic                m_recv_val,
  input  logic                m_recv_rdy,
  output logic [NBITS-1:0]    m_recv_msg,
  input  logic                m_send_val,
  output logic                m_send_rdy,
  input  logic [NBITS-1:0]    m_send_msg,
  output logic                m_size_val,
  output logic [LOG_BITS-1:0] m_size_msg,
  output logic                m_cs_val,
  output logic [LOG_CS-1:0]   m_cs_msg,
  output logic                m_freq_val,
  output logic [2:0]          m_freq_msg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CFG  = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [LOG_BITS-1:0] c_max_size = LOG_BITS'(NBITS);

  state_t              r_state;
  state_t              w_next;
  logic [NBITS-1:0]    r_data;
  logic [LOG_BITS-1:0] r_size;
  logic [LOG_CS-1:0]   r_cs;
  logic [2:0]          r_freq;
  logic [NBITS-1:0]    r_resp_data;
  logic                r_resp_err;
  logic                w_size_bad;
  logic                w_accept;
  logic                w_cache_hit;
  logic [NBITS-1:0]    w_mask;

  assign w_size_bad = (req_size == '0) || (req_size > c_max_size);
  assign w_accept   = (r_state == ST_IDLE) && req_val;
  // Shifting by NBITS clears every bit, so size == NBITS yields an all-ones mask.
  assign w_mask     = ~({NBITS{1'b1}} << r_size);

`ifdef SPI_SEQ_CFG_CACHE_EN
  logic                r_cache_val;
  logic [LOG_BITS-1:0] r_cache_size;
  logic [LOG_CS-1:0]   r_cache_cs;
  logic [2:0]          r_cache_freq;

  assign w_cache_hit = r_cache_val && (req_size == r_cache_size) &&
                       (req_cs == r_cache_cs) && (req_freq == r_cache_freq);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cache_val  <= 1'b0;
      r_cache_size <= '0;
      r_cache_cs   <= '0;
      r_cache_freq <= '0;
    end else if (w_accept && w_size_bad) begin
      r_cache_val <= 1'b0;
    end else if ((r_state == ST_CFG) && m_recv_rdy) begin
      r_cache_val  <= 1'b1;
      r_cache_size <= r_size;
      r_cache_cs   <= r_cs;
      r_cache_freq <= r_freq;
    end
  end
`else
  assign w_cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_rdy    = 1'b0;
    busy       = 1'b1;
    m_size_val = 1'b0;
    m_cs_val   = 1'b0;
    m_freq_val = 1'b0;
    m_recv_val = 1'b0;
    m_send_rdy = 1'b0;
    resp_val   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        busy    = 1'b0;
        if (req_val) begin
          if (w_size_bad)       w_next = ST_RESP;
          else if (w_cache_hit) w_next = ST_SEND;
          else                  w_next = ST_CFG;
        end
      end
      ST_CFG: begin
        m_size_val = 1'b1;
        m_cs_val   = 1'b1;
        m_freq_val = 1'b1;
        if (m_recv_rdy) w_next = ST_SEND;
      end
      ST_SEND: begin
        // Hold off while the master still presents a result, so it cannot restart early.
        m_recv_val = !m_send_val;
        if (m_recv_rdy && !m_send_val) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        m_send_rdy = 1'b1;
        if (m_send_val) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_size      <= '0;
      r_cs        <= '0;
      r_freq      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data <= req_data;
        r_size <= req_size;
        r_cs   <= req_cs;
        r_freq <= req_freq;
        if (w_size_bad) begin
          r_resp_data <= '0;
          r_resp_err  <= 1'b1;
        end
      end
      if ((r_state == ST_WAIT) && m_send_val) begin
        r_resp_data <= m_send_msg & w_mask;
        r_resp_err  <= 1'b0;
      end
    end
  end

  assign m_recv_msg = r_data;
  assign m_size_msg = r_size;
  assign m_cs_msg   = r_cs;
  assign m_freq_msg = r_freq;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// Bench for spi_txn_sequencer: behavioural SPI master plus a reference model of
// masking, error rules, latency and the optional config cache.
module tb_spi_txn_sequencer;
  localparam int NB = 34;
  localparam int LB = 7;
  localparam int LC = 1;
`ifdef SPI_SEQ_CFG_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val, req_rdy;
  logic [NB-1:0] req_data;
  logic [LB-1:0] req_size;
  logic [LC-1:0] req_cs;
  logic [2:0]    req_freq;
  logic          resp_val, resp_rdy, resp_err, busy;
  logic [NB-1:0] resp_data;
  logic          m_recv_val, m_recv_rdy, m_send_val, m_send_rdy;
  logic [NB-1:0] m_recv_msg, m_send_msg;
  logic          m_size_val, m_cs_val, m_freq_val;
  logic [LB-1:0] m_size_msg;
  logic [LC-1:0] m_cs_msg;
  logic [2:0]    m_freq_msg;

  always #5 clk = ~clk;

  spi_txn_sequencer #(.NBITS(34), .NCS(1), .LOG_BITS(7), .LOG_CS(1)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_data(req_data), .req_size(req_size),
    .req_cs(req_cs), .req_freq(req_freq),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy),
    .m_recv_val(m_recv_val), .m_recv_rdy(m_recv_rdy), .m_recv_msg(m_recv_msg),
    .m_send_val(m_send_val), .m_send_rdy(m_send_rdy), .m_send_msg(m_send_msg),
    .m_size_val(m_size_val), .m_size_msg(m_size_msg),
    .m_cs_val(m_cs_val), .m_cs_msg(m_cs_msg),
    .m_freq_val(m_freq_val), .m_freq_msg(m_freq_msg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference cache state: last programmed config and its validity.
  bit            mc_val = 1'b0;
  logic [LB-1:0] mc_size;
  logic [LC-1:0] mc_cs;
  logic [2:0]    mc_freq;

  // Observations returned by the transaction driver.
  logic [NB-1:0] t_data, t_sent;
  logic          t_err;
  int            t_lat, t_cfg, t_cfgv, t_recv, t_viol;

  function automatic logic [NB-1:0] exp_mask(input int sz);
    logic [63:0] m;
    if (sz >= NB) m = {64{1'b1}};
    else          m = (64'd1 << sz) - 64'd1;
    return m[NB-1:0];
  endfunction

  function automatic bit size_ok(input logic [LB-1:0] sz);
    return (int'(sz) >= 1) && (int'(sz) <= NB);
  endfunction

  function automatic bit model_hit(input logic [LB-1:0] sz, input logic [LC-1:0] cs, input logic [2:0] fq);
    return CACHE_EN && mc_val && (sz == mc_size) && (cs == mc_cs) && (fq == mc_freq);
  endfunction

  task automatic model_update(input logic [LB-1:0] sz, input logic [LC-1:0] cs, input logic [2:0] fq);
    if (!size_ok(sz)) mc_val = 1'b0;
    else begin
      mc_val = 1'b1; mc_size = sz; mc_cs = cs; mc_freq = fq;
    end
  endtask

  task automatic idle_inputs();
    req_val = 1'b0; req_data = '0; req_size = '0; req_cs = '0; req_freq = '0;
    resp_rdy = 1'b0; m_recv_rdy = 1'b1; m_send_val = 1'b0; m_send_msg = '0;
  endtask

  // Issues one request and plays the SPI master; entered and left just after a negedge.
  task automatic run_txn(input logic [NB-1:0] data, input logic [LB-1:0] size, input logic [LC-1:0] cs,
                         input logic [2:0] freq, input int xfer, input bit stall, input int stale,
                         input int hold, input bit ones);
    int phase = 0;
    int cnt = 0;
    bit done = 1'b0;
    logic [NB-1:0] miso = '0;
    logic [NB-1:0] junk;
    t_cfg = 0; t_cfgv = 0; t_recv = 0; t_viol = 0; t_lat = -1;
    t_sent = '0; t_data = '0; t_err = 1'b0;
    req_val = 1'b1; req_data = data; req_size = size; req_cs = cs; req_freq = freq;
    resp_rdy = 1'b0; m_recv_rdy = 1'b1; m_send_val = 1'b0;
    #1;
    if (req_rdy !== 1'b1) t_viol++;
    @(negedge clk);
    req_val = 1'b0; req_data = NB'({$urandom(), $urandom()}); req_size = LB'($urandom());
    for (int k = 1; k <= 400 && !done; k++) begin
      if (phase == 1) begin
        if (cnt == 0) phase = 2;
        else cnt--;
      end
      if (k <= stale) begin
        m_send_val = 1'b1; m_send_msg = NB'({$urandom(), $urandom()}); m_recv_rdy = 1'b1;
      end else if (phase == 0) begin
        m_send_val = 1'b0; m_recv_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else if (phase == 1) begin
        m_send_val = 1'b0; m_recv_rdy = 1'b0;
      end else begin
        m_send_val = 1'b1; m_send_msg = miso; m_recv_rdy = 1'b0;
      end
      #1;
      if (m_recv_val && m_send_val) t_viol++;
      if ((m_size_val !== m_cs_val) || (m_size_val !== m_freq_val)) t_viol++;
      if (m_size_val) begin
        t_cfgv++;
        if ((m_size_msg !== size) || (m_cs_msg !== cs) || (m_freq_msg !== freq)) t_viol++;
        if (m_recv_rdy) t_cfg++;
      end
      if (m_recv_val && m_recv_rdy) begin
        t_recv++;
        t_sent = m_recv_msg;
        junk = NB'({$urandom(), $urandom()});
        miso = ones ? {NB{1'b1}}
                    : ((m_recv_msg & exp_mask(int'(size))) | (junk & ~exp_mask(int'(size))));
        phase = 1; cnt = xfer;
      end else if (phase == 2 && m_send_val && m_send_rdy) begin
        phase = 0;
      end
      if (resp_val) begin
        t_lat = k; t_data = resp_data; t_err = resp_err;
        for (int j = 0; j < hold; j++) begin
          @(negedge clk);
          m_send_val = 1'b0; m_recv_rdy = 1'b1;
          #1;
          if (resp_val !== 1'b1 || resp_data !== t_data || resp_err !== t_err || req_rdy !== 1'b0 ||
              m_send_rdy !== 1'b0 || busy !== 1'b1 || m_recv_val !== 1'b0 || m_size_val !== 1'b0)
            t_viol++;
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0; m_send_val = 1'b0; m_recv_rdy = 1'b1;
        #1;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1 || busy !== 1'b0) t_viol++;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      t_viol += 1000;
      reset = 1'b1; idle_inputs();
      @(negedge clk); @(negedge clk);
      reset = 1'b0; mc_val = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if ({resp_val, m_recv_val, m_send_rdy, m_size_val, m_cs_val, m_freq_val} !== 6'b0) begin
      n_err++; $display("FAIL reset_vals: got %b want 000000",
                        {resp_val, m_recv_val, m_send_rdy, m_size_val, m_cs_val, m_freq_val});
    end
    n_vec++; if (resp_err !== 1'b0 || resp_data !== '0) begin
      n_err++; $display("FAIL reset_resp: got err=%b data=%h want 0/0", resp_err, resp_data);
    end
    n_vec++; if (m_recv_msg !== '0 || m_size_msg !== '0) begin
      n_err++; $display("FAIL reset_latch: got data=%h size=%0d want 0/0", m_recv_msg, m_size_msg);
    end
    reset = 1'b0; mc_val = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    bit hit;
    hit = model_hit(7'd8, 1'b0, 3'd0);
    run_txn(34'hA5, 7'd8, 1'b0, 3'd0, 8, 1'b0, 0, 0, 1'b0);
    model_update(7'd8, 1'b0, 3'd0);
    n_vec++; if (t_data !== 34'hA5 || t_err !== 1'b0) begin
      n_err++; $display("FAIL a5_resp: got data=%h err=%b want a5/0", t_data, t_err);
    end
    n_vec++; if (t_cfg !== (hit ? 0 : 1) || t_cfgv !== (hit ? 0 : 1) || t_recv !== 1) begin
      n_err++; $display("FAIL a5_pulses: got cfg=%0d recv=%0d want %0d/1", t_cfg, t_recv, hit ? 0 : 1);
    end
    n_vec++; if (t_sent !== 34'hA5) begin n_err++; $display("FAIL a5_mosi: got %h want a5", t_sent); end
    n_vec++; if (t_lat !== 8 + 4 - (hit ? 1 : 0)) begin
      n_err++; $display("FAIL a5_latency: got %0d want %0d", t_lat, 8 + 4 - (hit ? 1 : 0));
    end
    n_vec++; if (t_viol !== 0) begin n_err++; $display("FAIL a5_protocol: got %0d want 0", t_viol); end
  endtask

  task automatic test_size_errors();
    logic [LB-1:0] bad [3];
    bad[0] = 7'd0; bad[1] = 7'd35; bad[2] = LB'($urandom_range(36, 127));
    foreach (bad[i]) begin
      run_txn(NB'({$urandom(), $urandom()}), bad[i], 1'b0, 3'd2, 3, 1'b0, 0, 1, 1'b0);
      model_update(bad[i], 1'b0, 3'd2);
      n_vec++; if (t_err !== 1'b1 || t_data !== '0) begin
        n_err++; $display("FAIL err_resp size=%0d: got err=%b data=%h want 1/0", bad[i], t_err, t_data);
      end
      n_vec++; if (t_lat !== 1) begin
        n_err++; $display("FAIL err_latency size=%0d: got %0d want 1", bad[i], t_lat);
      end
      n_vec++; if (t_cfgv !== 0 || t_recv !== 0 || t_viol !== 0) begin
        n_err++; $display("FAIL err_quiet size=%0d: got cfg=%0d recv=%0d viol=%0d want 0/0/0",
                          bad[i], t_cfgv, t_recv, t_viol);
      end
    end
  endtask

  task automatic test_size_bounds();
    run_txn({NB{1'b1}}, 7'd34, 1'b1, 3'd1, 4, 1'b0, 0, 0, 1'b1);
    model_update(7'd34, 1'b1, 3'd1);
    n_vec++; if (t_data !== {NB{1'b1}} || t_err !== 1'b0 || t_viol !== 0) begin
      n_err++; $display("FAIL full_size: got data=%h err=%b viol=%0d want all-ones/0/0", t_data, t_err, t_viol);
    end
    run_txn(NB'({$urandom(), $urandom()}), 7'd4, 1'b0, 3'd1, 2, 1'b0, 0, 0, 1'b1);
    model_update(7'd4, 1'b0, 3'd1);
    n_vec++; if (t_data !== 34'hF || t_err !== 1'b0 || t_viol !== 0) begin
      n_err++; $display("FAIL size4_ones: got data=%h err=%b viol=%0d want f/0/0", t_data, t_err, t_viol);
    end
  endtask

  task automatic test_resp_hold();
    logic [NB-1:0] d;
    d = NB'({$urandom(), $urandom()});
    run_txn(d, 7'd20, 1'b0, 3'd3, 5, 1'b0, 0, 20, 1'b0);
    model_update(7'd20, 1'b0, 3'd3);
    n_vec++; if (t_data !== (d & 34'hF_FFFF) || t_err !== 1'b0) begin
      n_err++; $display("FAIL hold_resp: got data=%h err=%b want %h/0", t_data, t_err, d & 34'hF_FFFF);
    end
    n_vec++; if (t_viol !== 0) begin n_err++; $display("FAIL hold_stable: got %0d violations want 0", t_viol); end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] d;
    bit h1, h2;
    int lat1, cfg1;
    d = NB'({$urandom(), $urandom()});
    h1 = model_hit(7'd12, 1'b1, 3'd5);
    run_txn(d, 7'd12, 1'b1, 3'd5, 2, 1'b0, 0, 0, 1'b0);
    model_update(7'd12, 1'b1, 3'd5);
    lat1 = t_lat; cfg1 = t_cfg;
    h2 = model_hit(7'd12, 1'b1, 3'd5);
    run_txn(d, 7'd12, 1'b1, 3'd5, 2, 1'b0, 0, 0, 1'b0);
    model_update(7'd12, 1'b1, 3'd5);
    n_vec++; if (cfg1 !== (h1 ? 0 : 1) || t_cfg !== (h2 ? 0 : 1)) begin
      n_err++; $display("FAIL b2b_cfg_pulses: got %0d,%0d want %0d,%0d", cfg1, t_cfg, h1 ? 0 : 1, h2 ? 0 : 1);
    end
    n_vec++; if (t_lat - lat1 !== (h1 ? 1 : 0) - (h2 ? 1 : 0)) begin
      n_err++; $display("FAIL b2b_latency: got %0d,%0d want delta %0d", lat1, t_lat, (h1 ? 1 : 0) - (h2 ? 1 : 0));
    end
    n_vec++; if (t_data !== (d & 34'hFFF) || t_viol !== 0) begin
      n_err++; $display("FAIL b2b_data: got %h viol=%0d want %h/0", t_data, t_viol, d & 34'hFFF);
    end
  endtask

  task automatic test_stale_result();
    logic [NB-1:0] d;
    d = NB'({$urandom(), $urandom()});
    run_txn(d, 7'd30, 1'b0, 3'd6, 3, 1'b0, 4, 0, 1'b0);
    model_update(7'd30, 1'b0, 3'd6);
    n_vec++; if (t_data !== (d & exp_mask(30)) || t_recv !== 1 || t_viol !== 0) begin
      n_err++; $display("FAIL stale_block: got data=%h recv=%0d viol=%0d want %h/1/0",
                        t_data, t_recv, t_viol, d & exp_mask(30));
    end
  endtask

  task automatic test_reset_in_wait();
    bit reached = 1'b0;
    logic [NB-1:0] d;
    d = NB'({$urandom(), $urandom()});
    run_txn(d, 7'd16, 1'b1, 3'd3, 1, 1'b0, 0, 0, 1'b0);
    model_update(7'd16, 1'b1, 3'd3);
    req_val = 1'b1; req_data = d; req_size = 7'd16; req_cs = 1'b1; req_freq = 3'd3;
    m_recv_rdy = 1'b1; m_send_val = 1'b0;
    @(negedge clk);
    req_val = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      #1;
      if (m_send_rdy === 1'b1) reached = 1'b1;
      else @(negedge clk);
    end
    n_vec++; if (!reached) begin n_err++; $display("FAIL rst_wait_reach: got no m_send_rdy want 1"); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || req_rdy !== 1'b1 ||
        {resp_val, m_recv_val, m_send_rdy, m_size_val, m_cs_val, m_freq_val} !== 6'b0) begin
      n_err++; $display("FAIL rst_wait_idle: got busy=%b rdy=%b vals=%b want 0/1/000000", busy, req_rdy,
                        {resp_val, m_recv_val, m_send_rdy, m_size_val, m_cs_val, m_freq_val});
    end
    reset = 1'b0; mc_val = 1'b0;
    @(negedge clk);
    run_txn(d, 7'd16, 1'b1, 3'd3, 2, 1'b0, 0, 0, 1'b0);
    model_update(7'd16, 1'b1, 3'd3);
    n_vec++; if (t_data !== (d & 34'hFFFF) || t_err !== 1'b0 || t_cfg !== 1 || t_viol !== 0) begin
      n_err++; $display("FAIL rst_wait_after: got data=%h err=%b cfg=%0d viol=%0d want %h/0/1/0",
                        t_data, t_err, t_cfg, t_viol, d & 34'hFFFF);
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] d, exp_d;
    logic [LB-1:0] sz, lsz;
    logic [LC-1:0] cs, lcs;
    logic [2:0]    fq, lfq;
    bit have_last = 1'b0;
    bit hit, ok, stall, ones;
    int xfer, stale, hold;
    for (int i = 0; i < 60; i++) begin
      if (have_last && $urandom_range(0, 9) < 4) begin
        sz = lsz; cs = lcs; fq = lfq;
      end else begin
        cs = LC'($urandom()); fq = 3'($urandom());
        if ($urandom_range(0, 9) == 0) sz = ($urandom_range(0, 1) == 0) ? 7'd0 : LB'($urandom_range(NB + 1, 127));
        else                           sz = LB'($urandom_range(1, NB));
      end
      d = NB'({$urandom(), $urandom()});
      xfer = $urandom_range(0, 6);
      stall = ($urandom_range(0, 3) == 0);
      stale = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      hold = $urandom_range(0, 2);
      ones = ($urandom_range(0, 4) == 0);
      hit = model_hit(sz, cs, fq);
      ok = size_ok(sz);
      run_txn(d, sz, cs, fq, xfer, stall, stale, hold, ones);
      model_update(sz, cs, fq);
      if (ok) begin
        have_last = 1'b1; lsz = sz; lcs = cs; lfq = fq;
      end
      exp_d = !ok ? '0 : (ones ? exp_mask(int'(sz)) : (d & exp_mask(int'(sz))));
      n_vec++; if (t_data !== exp_d || t_err !== !ok) begin
        n_err++; $display("FAIL rnd%0d_resp size=%0d: got data=%h err=%b want %h/%b", i, sz, t_data, t_err, exp_d, !ok);
      end
      n_vec++; if (t_viol !== 0) begin n_err++; $display("FAIL rnd%0d_protocol: got %0d want 0", i, t_viol); end
      n_vec++;
      if (t_cfg !== ((ok && !hit) ? 1 : 0) || t_recv !== (ok ? 1 : 0) || (ok && t_sent !== d)) begin
        n_err++; $display("FAIL rnd%0d_handshakes: got cfg=%0d recv=%0d sent=%h want %0d/%0d/%h",
                          i, t_cfg, t_recv, t_sent, (ok && !hit) ? 1 : 0, ok ? 1 : 0, d);
      end
      if (!ok || (!stall && stale == 0)) begin
        n_vec++;
        if (t_lat !== (ok ? xfer + 4 - (hit ? 1 : 0) : 1)) begin
          n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, t_lat, ok ? xfer + 4 - (hit ? 1 : 0) : 1);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_a5();
    test_size_errors();
    test_size_bounds();
    test_resp_hold();
    test_back_to_back();
    test_stale_result();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
